// File: rtl/imem_responder.sv
// Instruction-memory responder: 1-cycle-latency word reads plus a byte-serial loader filling RAM from word 0.
// Optional macro IMEM_LOAD_CHECKSUM_EN builds a 16-bit wrapping sum of loaded words on ld_checksum.
//
// state   | meaning
// IDLE    | serving fetch reads; waiting for ld_start
// LOAD_LO | waiting for the low byte of the next word
// LOAD_HI | waiting for the high byte; writes the word and advances the pointer
module imem_responder #(
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst_async_n,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [15:0]       rsp_data,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [7:0]        ld_byte,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              busy,
  output logic [15:0]       ld_checksum
);

  typedef enum logic [1:0] {IDLE, LOAD_LO, LOAD_HI} state_t;

  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic [7:0]        lo, lo_nxt;
  logic              wr_en;
  logic [15:0]       wr_data;
  logic              done_nxt;

  logic [15:0] mem [2**ADDR_W];

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    lo_nxt    = lo;
    wr_en     = 1'b0;
    wr_data   = 16'h0000;
    done_nxt  = 1'b0;
    req_ready = 1'b0;
    ld_ready  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (ld_start) begin
          state_nxt = LOAD_LO;
          ptr_nxt   = '0;
        end
      end
      LOAD_LO: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          if (ld_last) begin
            // odd-length image: zero-pad the final word
            wr_en     = 1'b1;
            wr_data   = {8'h00, ld_byte};
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            lo_nxt    = ld_byte;
            state_nxt = LOAD_HI;
          end
        end
      end
      LOAD_HI: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          wr_en   = 1'b1;
          wr_data = {ld_byte, lo};
          ptr_nxt = ptr + PTR_ONE;
          if (ld_last || (ptr == '1)) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = LOAD_LO;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      state     <= IDLE;
      ptr       <= '0;
      lo        <= 8'h00;
      ld_done   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 16'h0000;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      lo        <= lo_nxt;
      ld_done   <= done_nxt;
      rsp_valid <= req_valid && req_ready;
      if (req_valid && req_ready) rsp_data <= mem[req_addr];
    end
  end

  // RAM contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[ptr] <= wr_data;
  end

  assign busy = (state != IDLE);

`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [15:0] csum;

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n)                   csum <= 16'h0000;
    else if ((state == IDLE) && ld_start) csum <= 16'h0000;
    else if (wr_en)                     csum <= csum + wr_data;
  end

  assign ld_checksum = csum;
`else
  assign ld_checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: read responses checked through an expected-data queue.
module tb_imem_responder;

  logic        clk = 1'b0;
  logic        rst_async_n;
  logic        req_valid;
  logic [12:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        ld_start;
  logic        ld_valid;
  logic [7:0]  ld_byte;
  logic        ld_last;
  logic        ld_ready;
  logic        ld_done;
  logic        busy;
  logic [15:0] ld_checksum;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] sb[$];
  bit          pushed = 1'b0;
  logic [15:0] csum_model;

`ifdef IMEM_LOAD_CHECKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  imem_responder #(.ADDR_W(13)) dut (
    .clk(clk), .rst_async_n(rst_async_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last),
    .ld_ready(ld_ready), .ld_done(ld_done), .busy(busy), .ld_checksum(ld_checksum)
  );

  function automatic logic [15:0] cs(input logic [15:0] v);
    return CS_EN ? v : 16'h0000;
  endfunction

  function automatic logic [7:0] b_of(input int i);
    int v;
    v = i * 7 + 3;
    return v[7:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, score the response, and clear one-cycle inputs.
  task automatic cyc();
    logic [15:0] e;
    @(negedge clk);
    chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, pushed});
    if (rsp_valid && sb.size() > 0) begin
      e = sb.pop_front();
      chk("rsp_data", {16'b0, rsp_data}, {16'b0, e});
    end
    pushed    = 1'b0;
    req_valid = 1'b0;
    ld_valid  = 1'b0;
    ld_start  = 1'b0;
    ld_last   = 1'b0;
  endtask

  task automatic rd(input logic [12:0] a, input logic [15:0] e);
    req_valid = 1'b1;
    req_addr  = a;
    sb.push_back(e);
    pushed = 1'b1;
  endtask

  task automatic lb(input logic [7:0] b, input logic last);
    ld_valid = 1'b1;
    ld_byte  = b;
    ld_last  = last;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
    chk({tag, "_ld_ready"},  {31'b0, ld_ready},  32'd0);
    chk({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_data"},  {16'b0, rsp_data},  32'd0);
    chk({tag, "_ld_done"},   {31'b0, ld_done},   32'd0);
    chk({tag, "_busy"},      {31'b0, busy},      32'd0);
    chk({tag, "_checksum"},  {16'b0, ld_checksum}, 32'd0);
  endtask

  initial begin
    rst_async_n = 1'b0;
    req_valid = 1'b0; req_addr = '0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_byte = 8'h00; ld_last = 1'b0;

    cyc(); cyc();
    chk_reset_outputs("reset");
    rst_async_n = 1'b1;
    cyc();

    // two-word load, then streamed reads 0,1,0
    ld_start = 1'b1; cyc();
    chk("ld1_busy", {31'b0, busy}, 32'd1);
    chk("ld1_ld_ready", {31'b0, ld_ready}, 32'd1);
    chk("ld1_req_ready", {31'b0, req_ready}, 32'd0);
    lb(8'h34, 1'b0); cyc();
    lb(8'h12, 1'b0); cyc();
    chk("ld1_done_early", {31'b0, ld_done}, 32'd0);
    lb(8'h78, 1'b0); cyc();
    lb(8'h56, 1'b1); cyc();
    chk("ld1_done", {31'b0, ld_done}, 32'd1);
    chk("ld1_busy_fall", {31'b0, busy}, 32'd0);
    chk("ld1_checksum", {16'b0, ld_checksum}, {16'b0, cs(16'h68AC)});
    cyc();
    chk("ld1_done_pulse", {31'b0, ld_done}, 32'd0);
    chk("ld1_checksum_hold", {16'b0, ld_checksum}, {16'b0, cs(16'h68AC)});
    rd(13'd0, 16'h1234); cyc();
    rd(13'd1, 16'h5678); cyc();
    rd(13'd0, 16'h1234); cyc();
    cyc();
    chk("rsp_data_hold", {16'b0, rsp_data}, 32'h1234);

    // odd-length load
    ld_start = 1'b1; cyc();
    lb(8'hAB, 1'b1); cyc();
    chk("odd_done", {31'b0, ld_done}, 32'd1);
    chk("odd_busy", {31'b0, busy}, 32'd0);
    chk("odd_req_ready", {31'b0, req_ready}, 32'd1);
    chk("odd_checksum", {16'b0, ld_checksum}, {16'b0, cs(16'h00AB)});
    rd(13'd0, 16'h00AB); cyc();
    cyc();

    // ld_start together with a read, then a full wrapping load
    ld_start = 1'b1; rd(13'd1, 16'h5678); cyc();
    chk("start_rd_busy", {31'b0, busy}, 32'd1);
    chk("start_rd_req_ready", {31'b0, req_ready}, 32'd0);
    csum_model = 16'h0000;
    for (int i = 0; i < 16384; i++) begin
      lb(b_of(i), 1'b0);
      if (i == 5) begin req_valid = 1'b1; req_addr = 13'd3; end
      if (i == 7) ld_start = 1'b1;
      cyc();
      if (i % 2 == 1) csum_model = csum_model + {b_of(i), b_of(i - 1)};
      chk("full_ld_done", {31'b0, ld_done}, {31'b0, (i == 16383)});
    end
    chk("full_busy", {31'b0, busy}, 32'd0);
    chk("full_checksum", {16'b0, ld_checksum}, {16'b0, cs(csum_model)});
    rd(13'd0, {b_of(1), b_of(0)}); cyc();
    rd(13'd8191, {b_of(16383), b_of(16382)}); cyc();
    rd(13'd1, {b_of(3), b_of(2)}); cyc();
    cyc();

    // reset in the middle of a load
    ld_start = 1'b1; cyc();
    lb(8'h11, 1'b0); cyc();
    lb(8'h22, 1'b0); cyc();
    lb(8'h33, 1'b0); cyc();
    chk("midrst_busy_before", {31'b0, busy}, 32'd1);
    rst_async_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    cyc();
    rst_async_n = 1'b1;
    cyc();
    chk("midrst_no_done", {31'b0, ld_done}, 32'd0);
    rd(13'd0, 16'h2211); cyc();
    rd(13'd1, {b_of(3), b_of(2)}); cyc();
    cyc();

    chk("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder: the memory-side end of the fetch unit's instruction read interface. It owns an 8192 x 16-bit synchronous instruction RAM and answers one word-address read per cycle with a 1-cycle latency. It also provides a byte-serial loader port that fills the RAM from word 0 upward. Fetch requests are held off while a load is in progress.

## Interface
Parameters:
- ADDR_W, 13, word-address width; RAM depth is 2**ADDR_W words of 16 bits.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst_async_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  fetch presents a read request.
- req_addr  in  ADDR_W  word address (PC[13:1]).
- req_ready  out  1  request accepted this cycle when high together with req_valid.
- rsp_valid  out  1  rsp_data holds the word for the request accepted one cycle earlier.
- rsp_data  out  16  instruction word, little-endian within the word.
- ld_start  in  1  single-cycle pulse; begins a load at word 0.
- ld_valid  in  1  loader byte present.
- ld_byte  in  8  loader byte.
- ld_last  in  1  qualifies ld_byte as the final byte of the image.
- ld_ready  out  1  loader byte accepted when high together with ld_valid.
- ld_done  out  1  one-cycle pulse when a load finishes.
- busy  out  1  high while in any LOAD state.
- ld_checksum  out  16  running checksum (see Configuration).

## Operation
- States: IDLE, LOAD_LO, LOAD_HI.
- IDLE:
  - req_ready=1, ld_ready=0.
  - An accepted request reads RAM[req_addr].
  - ld_start moves the block to LOAD_LO, clears the write pointer to 0 and clears the checksum.
- LOAD_LO:
  - req_ready=0, ld_ready=1.
  - An accepted byte is latched as the low byte, then the state moves to LOAD_HI.
  - If ld_last=1 on that byte, the block writes {8'h00, byte} at the pointer, pulses ld_done and returns to IDLE.
- LOAD_HI:
  - req_ready=0, ld_ready=1.
  - An accepted byte writes {byte, lo} at the pointer and increments the pointer.
  - The state returns to LOAD_LO, or to IDLE with an ld_done pulse if ld_last=1 or the pointer wrapped from 2**ADDR_W-1 to 0.
- ld_start outside IDLE is ignored.
- A read and a write never occur in the same cycle, because req_ready is 0 in the LOAD states.
- Pointer arithmetic is ADDR_W bits and wraps modulo 2**ADDR_W.
- RAM contents are not cleared by reset.

## Timing
- Read latency is 1 cycle.
  - A request accepted at edge N gives rsp_valid=1 and valid rsp_data in the cycle after edge N.
  - Back-to-back requests stream at one word per cycle.
- rsp_valid is low in any cycle not following an accepted request.
- rsp_data holds its last value while rsp_valid=0.
- ld_start and an accepted request in the same IDLE cycle: the read completes normally (rsp_valid the next cycle) and the state enters LOAD_LO at the same edge.
- A load byte is accepted at most once per cycle. The RAM write happens at the accepting edge, so a read issued after returning to IDLE sees the new data.
- ld_done is high for exactly the cycle after the final accepting edge. busy falls in that same cycle.
- Reset values:
  - state IDLE, req_ready=1, ld_ready=0.
  - rsp_valid=0, rsp_data=16'h0000.
  - ld_done=0, busy=0, ld_checksum=16'h0000, pointer=0.
- Reset asserted mid-load: the load is abandoned, words already written remain, a partial low byte is discarded, and no ld_done is produced.

## Configuration
- IMEM_LOAD_CHECKSUM_EN defined:
  - ld_checksum accumulates the 16-bit wrapping sum of every word written during a load.
  - It is cleared on ld_start and is stable from the ld_done cycle until the next ld_start.
- Undefined: ld_checksum is tied to 16'h0000 and the accumulator is not built.

## Test plan
- Reset, then load bytes 34,12,78,56 (last on 56), then read addr 0 and 1 -> RAM[0]=16'h1234, RAM[1]=16'h5678; ld_done is one pulse; checksum 16'h68AC with the macro, 0 without it.
- Streamed reads of addr 0,1,0 on consecutive cycles -> rsp_valid high for 3 consecutive cycles with data 1234, 5678, 1234.
- Odd-length load 0xAB with ld_last -> RAM[0]=16'h00AB; the state returns to IDLE after 1 byte.
- ld_start together with a request to addr 1 in IDLE -> next cycle rsp_data=16'h5678, rsp_valid=1, busy=1, req_ready=0.
- Full 16384-byte load without ld_last -> the pointer wraps, ld_done fires after the 16384th byte, and RAM[8191] holds the last pair.
- Assert rst_async_n low after 3 bytes of a load -> all outputs take their reset values immediately; RAM[0] keeps its new word and RAM[1] is unchanged.
